// File: rtl/id_hazard_pkg.sv
// Shared types, producer latencies and tag-mapping helpers for the ID-stage hazard scoreboard.
package id_hazard_pkg;

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned NUM_TAGS = 64;
  localparam int unsigned FP_BASE  = 32;

  typedef logic [TAG_W-1:0] reg_tag_t;

  localparam reg_tag_t TAG_R0 = '0;

  localparam int unsigned LAT_ALU     = 1;
  localparam int unsigned LAT_LOAD    = 2;
  localparam int unsigned LAT_FPU_ADD = 3;
  localparam int unsigned LAT_FPU_MUL = 5;
  localparam int unsigned LAT_FPU_DIV = 7;

  // Counter index -> tag: integer r1..rN-1 first, then the FP file at FP_BASE.
  function automatic reg_tag_t tracked_tag(int unsigned idx, int unsigned num_int);
    if (idx < num_int - 1) return reg_tag_t'(idx + 1);
    return reg_tag_t'(FP_BASE + idx - (num_int - 1));
  endfunction

  function automatic logic tag_tracked(int unsigned t, int unsigned num_int,
                                       int unsigned num_fp);
    if (t < FP_BASE) return (t != 0) && (t < num_int);
    return (t - FP_BASE) < num_fp;
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage issue request and hazard response bundle.
interface id_hazard_scoreboard_if
  import id_hazard_pkg::*;
#(
  parameter int unsigned LAT_W = 3
);
  logic             issue_valid;
  logic             issue_flush;
  logic             rd_en;
  reg_tag_t         rd_tag;
  logic [LAT_W-1:0] rd_lat;
  logic             rs_a_en;
  reg_tag_t         rs_a_tag;
  logic             rs_b_en;
  reg_tag_t         rs_b_tag;
  logic             Stall_ID;
  logic             FWD_A;
  logic             FWD_B;

  modport master (
    output issue_valid, issue_flush, rd_en, rd_tag, rd_lat,
           rs_a_en, rs_a_tag, rs_b_en, rs_b_tag,
    input  Stall_ID, FWD_A, FWD_B
  );

  modport slave (
    input  issue_valid, issue_flush, rd_en, rd_tag, rd_lat,
           rs_a_en, rs_a_tag, rs_b_en, rs_b_tag,
    output Stall_ID, FWD_A, FWD_B
  );
endinterface

// File: rtl/hazard_reg_counter.sv
// Per-register countdown of cycles until its pending result is produced.
module hazard_reg_counter #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] value,
  output logic             busy,
  output logic             ready_next,
  output logic [LAT_W-1:0] cnt
);

  // A new issue overrides the decrement of an older producer.
  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (load)           cnt <= value;
    else if (cnt != '0)      cnt <= cnt - LAT_W'(1);
  end

  assign busy       = (cnt != '0);
  assign ready_next = (cnt == LAT_W'(1));

endmodule

// File: rtl/id_hazard_scoreboard.sv
// RAW/WAW hazard scoreboard for the ID stage: per-register countdowns drive Stall_ID,
// forward selects and a saturating stall counter. Forwarding enabled by ID_HAZARD_FWD_EN.
module id_hazard_scoreboard
  import id_hazard_pkg::*;
#(
  parameter int unsigned NUM_INT_REGS = 32,
  parameter int unsigned NUM_FP_REGS  = 32,
  parameter int unsigned LAT_W        = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  id_hazard_scoreboard_if.slave  bus,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

`ifdef ID_HAZARD_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam int unsigned NUM_TRACKED = NUM_INT_REGS - 1 + NUM_FP_REGS;

  logic             busy_v  [NUM_TAGS];
  logic             ready_v [NUM_TAGS];
  logic [LAT_W-1:0] cnt_v   [NUM_TAGS];

  logic             accept_c;
  logic             load_en_c;
  logic             haz_a_c;
  logic             haz_b_c;
  logic             waw_c;
  logic             stall_c;

  assign accept_c  = bus.issue_valid & ~stall_c & ~bus.issue_flush;
  assign load_en_c = accept_c & bus.rd_en & (bus.rd_lat != '0) & (bus.rd_tag != TAG_R0);

  for (genvar i = 0; i < NUM_TRACKED; i++) begin : g_cnt
    localparam reg_tag_t TAG = tracked_tag(i, NUM_INT_REGS);
    hazard_reg_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (load_en_c && (bus.rd_tag == TAG)),
      .value      (bus.rd_lat),
      .busy       (busy_v[TAG]),
      .ready_next (ready_v[TAG]),
      .cnt        (cnt_v[TAG])
    );
  end

  // r0 and any tag beyond the configured register files read as permanently idle.
  for (genvar t = 0; t < NUM_TAGS; t++) begin : g_idle
    if (!tag_tracked(t, NUM_INT_REGS, NUM_FP_REGS)) begin : g_tie
      assign busy_v[t]  = 1'b0;
      assign ready_v[t] = 1'b0;
      assign cnt_v[t]   = '0;
    end
  end

  // With forwarding, a producer one cycle from completion is consumed off the bypass.
  assign haz_a_c = bus.rs_a_en & busy_v[bus.rs_a_tag] & ~(FWD_EN & ready_v[bus.rs_a_tag]);
  assign haz_b_c = bus.rs_b_en & busy_v[bus.rs_b_tag] & ~(FWD_EN & ready_v[bus.rs_b_tag]);
  assign waw_c   = bus.rd_en & (bus.rd_lat != '0) & (bus.rd_lat <= cnt_v[bus.rd_tag]);
  assign stall_c = bus.issue_valid & ~bus.issue_flush & (haz_a_c | haz_b_c | waw_c);

  assign bus.Stall_ID = stall_c;
  assign bus.FWD_A    = FWD_EN & ~stall_c & bus.rs_a_en & ready_v[bus.rs_a_tag];
  assign bus.FWD_B    = FWD_EN & ~stall_c & bus.rs_b_en & ready_v[bus.rs_b_tag];

  always_ff @(posedge clk) begin
    if (reset)                               STALL_CNT <= '0;
    else if (stall_c && (STALL_CNT != '1))   STALL_CNT <= STALL_CNT + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard against a per-register countdown model.
// Honours ID_HAZARD_FWD_EN the same way as the design.
module tb_id_hazard_scoreboard;
  import id_hazard_pkg::*;

  localparam int unsigned LAT_W  = 3;
  localparam int unsigned SC_W   = 4;
  localparam int          SC_MAX = (1 << SC_W) - 1;
`ifdef ID_HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [SC_W-1:0] stall_cnt;
  int              checks = 0;
  int              errors = 0;

  int m_cnt [64];
  int m_sc;

  id_hazard_scoreboard_if #(.LAT_W(LAT_W)) bus ();

  id_hazard_scoreboard #(
    .NUM_INT_REGS (32),
    .NUM_FP_REGS  (32),
    .LAT_W        (LAT_W),
    .STALL_CNT_W  (SC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .STALL_CNT (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_too_early(int c);
    return FWD_ON ? (c >= 2) : (c != 0);
  endfunction

  function automatic bit m_stall();
    bit ha, hb, waw;
    int lat;
    lat = int'(bus.rd_lat);
    ha  = bus.rs_a_en && m_too_early(m_cnt[bus.rs_a_tag]);
    hb  = bus.rs_b_en && m_too_early(m_cnt[bus.rs_b_tag]);
    waw = bus.rd_en && (lat != 0) && (lat <= m_cnt[bus.rd_tag]);
    return bus.issue_valid && !bus.issue_flush && (ha || hb || waw);
  endfunction

  function automatic bit m_fwd_a();
    return FWD_ON && !m_stall() && bus.rs_a_en && (m_cnt[bus.rs_a_tag] == 1);
  endfunction

  function automatic bit m_fwd_b();
    return FWD_ON && !m_stall() && bus.rs_b_en && (m_cnt[bus.rs_b_tag] == 1);
  endfunction

  task automatic drive(input bit iv, input bit fl, input bit rde, input logic [5:0] rdt,
                       input int lat, input bit ae, input logic [5:0] at,
                       input bit be, input logic [5:0] bt);
    bus.issue_valid = iv;
    bus.issue_flush = fl;
    bus.rd_en       = rde;
    bus.rd_tag      = rdt;
    bus.rd_lat      = LAT_W'(lat);
    bus.rs_a_en     = ae;
    bus.rs_a_tag    = at;
    bus.rs_b_en     = be;
    bus.rs_b_tag    = bt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 6'd0);
  endtask

  // Advance one clock, moving the model by the scoreboard rules.
  task automatic tick();
    int nxt [64];
    int sc_n;
    bit st;
    st   = m_stall();
    sc_n = m_sc;
    for (int t = 0; t < 64; t++) nxt[t] = (m_cnt[t] > 0) ? m_cnt[t] - 1 : 0;
    if (!st && bus.issue_valid && !bus.issue_flush && bus.rd_en &&
        bus.rd_lat != 0 && bus.rd_tag != 0)
      nxt[bus.rd_tag] = int'(bus.rd_lat);
    if (st && sc_n < SC_MAX) sc_n++;
    if (reset) begin
      for (int t = 0; t < 64; t++) nxt[t] = 0;
      sc_n = 0;
    end
    @(posedge clk);
    for (int t = 0; t < 64; t++) m_cnt[t] = nxt[t];
    m_sc = sc_n;
    #1;
  endtask

  task automatic settle(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 6'd0, 0, 1, 6'd3, 1, 6'h22);
    #1;
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    checks++;
    if (bus.Stall_ID !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", bus.Stall_ID);
    end
    checks++;
    if ({bus.FWD_A, bus.FWD_B} !== 2'b00) begin
      errors++; $display("FAIL reset_fwd: got %b%b expected 00", bus.FWD_A, bus.FWD_B);
    end
    settle(2);
  endtask

  // Producer then a dependent consumer; count bubbles and check the forward select.
  task automatic test_raw(input string nm, input logic [5:0] tag, input int lat,
                          input bit use_b);
    int  stalls;
    bit  done, exp, got_f, exp_f;
    drive(1, 0, 1, tag, lat, 0, 6'd0, 0, 6'd0);
    #1;
    checks++;
    if (bus.Stall_ID !== 1'b0) begin
      errors++; $display("FAIL %s_producer_stall: got %b expected 0", nm, bus.Stall_ID);
    end
    tick();
    if (use_b) drive(1, 0, 0, 6'd0, 0, 0, 6'd0, 1, tag);
    else       drive(1, 0, 0, 6'd0, 0, 1, tag, 0, 6'd0);
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      exp = m_stall();
      checks++;
      if (bus.Stall_ID !== exp) begin
        errors++; $display("FAIL %s_stall_c%0d: got %b expected %b", nm, c, bus.Stall_ID, exp);
      end
      if (!exp) done = 1;
      else begin stalls++; tick(); end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s_timeout: got stalled expected release", nm);
    end
    checks++;
    if (stalls != (FWD_ON ? lat - 1 : lat)) begin
      errors++; $display("FAIL %s_bubbles: got %0d expected %0d", nm, stalls,
                         FWD_ON ? lat - 1 : lat);
    end
    got_f = use_b ? bus.FWD_B : bus.FWD_A;
    exp_f = use_b ? m_fwd_b() : m_fwd_a();
    checks++;
    if (got_f !== exp_f || exp_f !== FWD_ON) begin
      errors++; $display("FAIL %s_fwd: got %b expected %b", nm, got_f, FWD_ON);
    end
    tick();
    checks++;
    if (stall_cnt !== SC_W'(m_sc)) begin
      errors++; $display("FAIL %s_stall_cnt: got %0d expected %0d", nm, stall_cnt, m_sc);
    end
    settle(8);
  endtask

  task automatic test_waw();
    int stalls;
    bit done, exp;
    drive(1, 0, 1, 6'h24, LAT_FPU_DIV, 0, 6'd0, 0, 6'd0);
    tick();
    drive(1, 0, 1, 6'h24, LAT_ALU, 0, 6'd0, 0, 6'd0);
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      exp = m_stall();
      checks++;
      if (bus.Stall_ID !== exp) begin
        errors++; $display("FAIL waw_stall_c%0d: got %b expected %b", c, bus.Stall_ID, exp);
      end
      if (!exp) done = 1;
      else begin stalls++; tick(); end
    end
    // The later lat-1 write must wait until the divide's countdown has run out.
    checks++;
    if (stalls != LAT_FPU_DIV) begin
      errors++; $display("FAIL waw_bubbles: got %0d expected %0d", stalls, LAT_FPU_DIV);
    end
    tick();
    settle(8);
  endtask

  task automatic test_r0_flush();
    drive(1, 0, 1, TAG_R0, LAT_FPU_MUL, 0, 6'd0, 0, 6'd0);
    tick();
    drive(1, 0, 0, 6'd0, 0, 1, TAG_R0, 0, 6'd0);
    #1;
    checks++;
    if (bus.Stall_ID !== 1'b0 || bus.FWD_A !== 1'b0) begin
      errors++; $display("FAIL r0_read: got stall %b fwd %b expected 0 0", bus.Stall_ID, bus.FWD_A);
    end
    tick();
    drive(1, 1, 1, 6'd7, LAT_FPU_MUL, 0, 6'd0, 0, 6'd0);
    tick();
    drive(1, 0, 0, 6'd0, 0, 1, 6'd7, 1, 6'd7);
    #1;
    checks++;
    if (bus.Stall_ID !== 1'b0 || bus.Stall_ID !== m_stall()) begin
      errors++; $display("FAIL flush_read: got %b expected 0", bus.Stall_ID);
    end
    checks++;
    if ({bus.FWD_A, bus.FWD_B} !== 2'b00) begin
      errors++; $display("FAIL flush_fwd: got %b%b expected 00", bus.FWD_A, bus.FWD_B);
    end
    settle(2);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 6'h22, LAT_FPU_MUL, 0, 6'd0, 0, 6'd0);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (m_cnt[6'h22] != 3) begin
      errors++; $display("FAIL mid_setup: got cnt %0d expected 3", m_cnt[6'h22]);
    end
    reset = 1'b1;
    drive(1, 0, 0, 6'd0, 0, 1, 6'h22, 0, 6'd0);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.Stall_ID !== 1'b0) begin
      errors++; $display("FAIL mid_reset_stall: got %b expected 0", bus.Stall_ID);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", stall_cnt);
    end
    settle(2);
  endtask

  // Self-dependent chain on f5 keeps stalling far past the counter range.
  task automatic test_saturation();
    int seen;
    bit exp;
    seen = 0;
    drive(1, 0, 1, 6'h25, LAT_FPU_DIV, 1, 6'h25, 0, 6'd0);
    for (int c = 0; c < 40; c++) begin
      #1;
      exp = m_stall();
      checks++;
      if (bus.Stall_ID !== exp) begin
        errors++; $display("FAIL sat_stall_c%0d: got %b expected %b", c, bus.Stall_ID, exp);
      end
      if (exp) seen++;
      tick();
    end
    checks++;
    if (seen < SC_MAX + 3 || stall_cnt !== SC_W'(SC_MAX) || m_sc != SC_MAX) begin
      errors++; $display("FAIL sat_count: got %0d expected %0d after %0d stalls",
                         stall_cnt, SC_MAX, seen);
    end
    settle(8);
  endtask

  function automatic logic [5:0] rand_tag();
    logic [5:0] pool [8];
    pool = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd31, 6'h22, 6'h24, 6'h3f};
    return pool[$urandom_range(0, 7)];
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            rand_tag(), $urandom_range(0, 7), $urandom_range(0, 1) == 1, rand_tag(),
            $urandom_range(0, 1) == 1, rand_tag());
      #1;
      checks++;
      if (bus.Stall_ID !== m_stall()) begin
        errors++; $display("FAIL rnd_stall_c%0d: got %b expected %b", c, bus.Stall_ID, m_stall());
      end
      checks++;
      if (bus.FWD_A !== m_fwd_a() || bus.FWD_B !== m_fwd_b()) begin
        errors++; $display("FAIL rnd_fwd_c%0d: got %b%b expected %b%b", c, bus.FWD_A, bus.FWD_B,
                           m_fwd_a(), m_fwd_b());
      end
      checks++;
      if (stall_cnt !== SC_W'(m_sc)) begin
        errors++; $display("FAIL rnd_cnt_c%0d: got %0d expected %0d", c, stall_cnt, m_sc);
      end
      tick();
    end
    settle(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int t = 0; t < 64; t++) m_cnt[t] = 0;
    m_sc = 0;
    test_reset();
    test_raw("alu_r3",  6'd3,  LAT_ALU,     1'b0);
    test_raw("load_r1", 6'd1,  LAT_LOAD,    1'b1);
    test_raw("fmul_f2", 6'h22, LAT_FPU_MUL, 1'b0);
    test_waw();
    test_r0_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
